// File: rtl/rf_pkg.sv
// Shared types and default sizing for the register file with sequenced clear.
package rf_pkg;

   // Clear sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int unsigned RF_W_DEF   = 8;
   localparam int unsigned RF_PW_DEF  = 4;
   localparam int unsigned RF_ACC_DEF = 0;

endpackage

// File: rtl/rf_clr_seq.sv
// Clear sequencer: walks every register index once after reset or a clear
// request, then pulses clr_done for a single cycle.
module rf_clr_seq
   import rf_pkg::*;
#(
   parameter int unsigned PW = RF_PW_DEF
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_clr_req,
   output logic          o_busy,
   output logic          o_clr_done,
   output logic [PW-1:0] o_idx
);

   localparam logic [PW-1:0] IDX_MAX = '1;

   state_t        r_state_q;
   state_t        w_state_d;
   logic [PW-1:0] r_idx_q;
   logic [PW-1:0] w_idx_d;

   // State and index registers; reset lands in CLEAR so the array is zeroed
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state_q <= CLEAR;
         r_idx_q   <= '0;
      end else begin
         r_state_q <= w_state_d;
         r_idx_q   <= w_idx_d;
      end
   end

   // Next-state logic; clr_req only matters in IDLE
   always_comb begin
      w_state_d = r_state_q;
      w_idx_d   = r_idx_q;
      unique case (r_state_q)
         IDLE: begin
            if (i_clr_req) begin
               w_state_d = CLEAR;
               w_idx_d   = '0;
            end
         end
         CLEAR: begin
            // Hold idx at the last entry rather than wrapping into a second pass
            if (r_idx_q == IDX_MAX) begin
               w_state_d = DONE;
            end else begin
               w_idx_d = r_idx_q + 1'b1;
            end
         end
         DONE: begin
            w_state_d = IDLE;
         end
         default: begin
            w_state_d = IDLE;
         end
      endcase
   end

   // Status outputs decoded from state
   always_comb begin
      o_busy     = (r_state_q == CLEAR);
      o_clr_done = (r_state_q == DONE);
      o_idx      = r_idx_q;
   end

endmodule

// File: rtl/rf_acc_clr.sv
// Accumulator-style register file with two combinational read ports and a
// sequenced full clear. Optional per-register even parity is compiled in
// with the RF_PARITY_EN macro.
module rf_acc_clr
   import rf_pkg::*;
#(
   parameter int unsigned W   = RF_W_DEF,
   parameter int unsigned PW  = RF_PW_DEF,
   parameter int unsigned ACC = RF_ACC_DEF
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_wr_en,
   input  logic          i_mov_instr,
   input  logic          i_imm_val,
   input  logic [PW-1:0] i_addr_a,
   input  logic [PW-1:0] i_addr_b,
   input  logic [W-1:0]  i_dat_in,
   input  logic          i_clr_req,
`ifdef RF_PARITY_EN
   input  logic          i_inj_par,
`endif
   output logic [W-1:0]  o_dat_a_out,
   output logic [W-1:0]  o_dat_b_out,
   output logic          o_busy,
   output logic          o_clr_done,
   output logic          o_par_err
);

   localparam int unsigned   NREG    = 2 ** PW;
   localparam logic [PW-1:0] ACC_IDX = PW'(ACC);

   if (PW > W) begin : g_pw_chk
      $error("rf_acc_clr: PW must not exceed W");
   end
   if (ACC >= NREG) begin : g_acc_chk
      $error("rf_acc_clr: ACC must index an existing register");
   end

   logic [W-1:0]  r_core [NREG];
   logic          w_busy;
   logic          w_clr_done;
   logic [PW-1:0] w_clr_idx;
   logic [PW-1:0] w_a_idx;
   logic          w_we;

   rf_clr_seq #(
      .PW (PW)
   ) u_seq (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_clr_req  (i_clr_req),
      .o_busy     (w_busy),
      .o_clr_done (w_clr_done),
      .o_idx      (w_clr_idx)
   );

   // Port-A index doubles as the write target
   always_comb begin
      w_a_idx = i_mov_instr ? i_addr_a : ACC_IDX;
      // A write coinciding with a clear request is dropped, not queued
      w_we    = i_wr_en & ~w_busy & ~i_clr_req;
   end

   // Data array: cleared one entry per cycle while busy, no direct reset
   always_ff @(posedge i_clk) begin
      if (w_busy) begin
         r_core[w_clr_idx] <= '0;
      end else if (w_we) begin
         r_core[w_a_idx] <= i_dat_in;
      end
   end

   // Read muxes; both ports read as zero while a clear is running
   always_comb begin
      o_dat_a_out = '0;
      o_dat_b_out = '0;
      if (!w_busy) begin
         o_dat_a_out = r_core[w_a_idx];
         o_dat_b_out = i_imm_val ? W'(i_addr_b) : r_core[i_addr_b];
      end
   end

`ifdef RF_PARITY_EN
   logic r_par [NREG];

   // Parity array tracks the data array; inj_par corrupts the stored bit
   always_ff @(posedge i_clk) begin
      if (w_busy) begin
         r_par[w_clr_idx] <= 1'b0;
      end else if (w_we) begin
         r_par[w_a_idx] <= (^i_dat_in) ^ i_inj_par;
      end
   end

   // Parity check on the register selected for port A
   always_comb begin
      o_par_err = ~w_busy & ((^r_core[w_a_idx]) != r_par[w_a_idx]);
   end
`else
   // Parity not built; error flag held low
   always_comb begin
      o_par_err = 1'b0;
   end
`endif

   // Sequencer status straight to the outputs
   always_comb begin
      o_busy     = w_busy;
      o_clr_done = w_clr_done;
   end

endmodule

// File: tb/tb_rf_acc_clr.sv
// Directed bench for rf_acc_clr: reset clear pass, port muxing, dropped
// writes, clear restart on reset, and parity when RF_PARITY_EN is defined.
module tb_rf_acc_clr;

   logic       clk;
   logic       reset;
   logic       wr_en;
   logic       mov_instr;
   logic       imm_val;
   logic [3:0] addr_a;
   logic [3:0] addr_b;
   logic [7:0] dat_in;
   logic       clr_req;
   logic [7:0] dat_a;
   logic [7:0] dat_b;
   logic       busy;
   logic       clr_done;
   logic       par_err;
`ifdef RF_PARITY_EN
   logic       inj_par;
`endif

   int checks = 0;
   int errors = 0;
   int n;

   rf_acc_clr #(
      .W   (8),
      .PW  (4),
      .ACC (0)
   ) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_wr_en     (wr_en),
      .i_mov_instr (mov_instr),
      .i_imm_val   (imm_val),
      .i_addr_a    (addr_a),
      .i_addr_b    (addr_b),
      .i_dat_in    (dat_in),
      .i_clr_req   (clr_req),
`ifdef RF_PARITY_EN
      .i_inj_par   (inj_par),
`endif
      .o_dat_a_out (dat_a),
      .o_dat_b_out (dat_b),
      .o_busy      (busy),
      .o_clr_done  (clr_done),
      .o_par_err   (par_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_busy(output int cnt);
      cnt = 0;
      while (busy && cnt < 40) begin
         step();
         cnt++;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      imm_val = 1'b0;
      for (int i = 0; i < 16; i++) begin
         addr_b = 4'(i);
         #1;
         chk(tag, {24'd0, dat_b}, 32'h0);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      mov_instr = 1'b1;
      addr_a    = a;
      dat_in    = d;
      wr_en     = 1'b1;
      step();
      wr_en     = 1'b0;
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      wr_en     = 1'b0;
      mov_instr = 1'b0;
      imm_val   = 1'b0;
      addr_a    = '0;
      addr_b    = '0;
      dat_in    = '0;
      clr_req   = 1'b0;
`ifdef RF_PARITY_EN
      inj_par   = 1'b0;
`endif
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_done", {31'd0, clr_done}, 32'd0);
      chk("rst_dat_a", {24'd0, dat_a}, 32'd0);
      repeat (2) step();
      chk("rst_busy_held", {31'd0, busy}, 32'd1);

      // Release: 16 clear cycles, then a single done pulse
      reset = 1'b0;
      #1;
      wait_busy(n);
      chk("rst_pass_len", n, 32'd16);
      chk("rst_done_pulse", {31'd0, clr_done}, 32'd1);
      chk("rst_done_nbusy", {31'd0, busy}, 32'd0);
      step();
      chk("rst_done_single", {31'd0, clr_done}, 32'd0);
      chk_all_zero("rst_zero");

      // Write via addr_a, then via ACC
      wr(4'd5, 8'hA5);
      chk("mov_r5", {24'd0, dat_a}, 32'hA5);
      mov_instr = 1'b0;
      dat_in    = 8'h3C;
      wr_en     = 1'b1;
      step();
      wr_en     = 1'b0;
      #1;
      chk("acc_r0", {24'd0, dat_a}, 32'h3C);
      mov_instr = 1'b1;
      addr_a    = 4'd5;
      #1;
      chk("r5_kept", {24'd0, dat_a}, 32'hA5);
      addr_b = 4'd0;
      #1;
      chk("portb_r0", {24'd0, dat_b}, 32'h3C);
`ifndef RF_PARITY_EN
      chk("par_tied0", {31'd0, par_err}, 32'd0);
`endif

      // Immediate on port B versus register read
      wr(4'd11, 8'h5E);
      imm_val = 1'b1;
      addr_b  = 4'hB;
      #1;
      chk("imm_b", {24'd0, dat_b}, 32'h0B);
      imm_val = 1'b0;
      #1;
      chk("reg_b11", {24'd0, dat_b}, 32'h5E);

      // Clear request with a coincident write; writes during busy ignored
      wr(4'd3, 8'h77);
      addr_b = 4'd3;
      #1;
      chk("r3_written", {24'd0, dat_b}, 32'h77);
      addr_a  = 4'd4;
      dat_in  = 8'h99;
      wr_en   = 1'b1;
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      #1;
      chk("clr_busy", {31'd0, busy}, 32'd1);
      chk("clr_dat_a0", {24'd0, dat_a}, 32'd0);
      imm_val = 1'b1;
      addr_b  = 4'hB;
      #1;
      chk("clr_imm0", {24'd0, dat_b}, 32'd0);
      imm_val = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         clr_req = (n == 5);
         step();
         n++;
      end
      wr_en   = 1'b0;
      clr_req = 1'b1;
      #1;
      chk("clr_pass_len", n, 32'd16);
      chk("clr_done_pulse", {31'd0, clr_done}, 32'd1);
      step();
      clr_req = 1'b0;
      #1;
      chk("clr_ign_done", {31'd0, busy}, 32'd0);
      chk("clr_done_single", {31'd0, clr_done}, 32'd0);
      chk_all_zero("clr_zero");

      // Reset at idx=7 restarts the pass from zero
      wr(4'd6, 8'h42);
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      repeat (7) step();
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", {31'd0, busy}, 32'd1);
      chk("mid_rst_done", {31'd0, clr_done}, 32'd0);
      step();
      reset = 1'b0;
      #1;
      wait_busy(n);
      chk("mid_pass_len", n, 32'd16);
      chk("mid_done_pulse", {31'd0, clr_done}, 32'd1);
      step();
      chk("mid_done_off1", {31'd0, clr_done}, 32'd0);
      step();
      chk("mid_done_off2", {31'd0, clr_done}, 32'd0);
      addr_b = 4'd6;
      #1;
      chk("mid_r6_zero", {24'd0, dat_b}, 32'd0);

`ifdef RF_PARITY_EN
      // Injected parity error, then a clean rewrite
      inj_par = 1'b1;
      wr(4'd2, 8'h01);
      inj_par = 1'b0;
      #1;
      chk("par_inj", {31'd0, par_err}, 32'd1);
      wr(4'd2, 8'h01);
      chk("par_clean", {31'd0, par_err}, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
